multi_key_debounce: RTL and testbench
=====================================

MULTI_KEY_DEBOUNCE -- requirements
Module: multi_key_debounce

Interface
REQ-001 Parameter N_CH, default 3, number of independent key channels (1..32).
REQ-002 Parameter CNT_W, default 20, width of each per-channel stability counter.
REQ-003 Parameter STABLE_CYC, default 1000000, consecutive clk cycles a changed input must hold before it is accepted; legal range 1..2^CNT_W-1.
REQ-004 Parameter REPEAT_CYC, default 25000000, auto-repeat interval in clk cycles; used only with KEY_REPEAT_EN.
REQ-005 clk  input  1  system clock, all logic on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_in  input  N_CH  raw asynchronous key levels, active-high.
REQ-008 key_level  output  N_CH  debounced stable level per channel.
REQ-009 press_p  output  N_CH  one-cycle pulse per accepted 0->1 transition (and per repeat, when enabled).
REQ-010 release_p  output  N_CH  one-cycle pulse per accepted 1->0 transition.

Function
REQ-011 Each key_in bit SHALL pass through a 2-flop synchronizer; the second stage is the channel's sampled value s[i].
REQ-012 Each channel SHALL hold an independent CNT_W-bit counter cnt[i]; channels SHALL not share or interact.
REQ-013 When s[i] equals key_level[i], cnt[i] SHALL be 0 on the next edge (any bounce restarts the count).
REQ-014 When s[i] differs from key_level[i] and cnt[i] < STABLE_CYC-1, cnt[i] SHALL increment by 1.
REQ-015 When s[i] differs from key_level[i] and cnt[i] == STABLE_CYC-1, key_level[i] SHALL take s[i] and cnt[i] SHALL clear to 0 on that edge.
REQ-016 press_p[i] (or release_p[i]) SHALL be registered, high for exactly the cycle following the edge on which key_level[i] rises (or falls), low otherwise.
REQ-017 Latency: a clean key_in step is reflected in key_level and the pulse 2+STABLE_CYC clk edges after the first edge sampling the new value.
REQ-018 press_p[i] and release_p[i] SHALL never be high in the same cycle; different channels MAY pulse in the same cycle.
REQ-019 A glitch shorter than STABLE_CYC cycles SHALL produce no change on key_level, press_p or release_p.
REQ-020 cnt[i] SHALL never exceed STABLE_CYC-1; no wrap-around is possible.

Reset
REQ-021 While rst_n is low: synchronizer flops, cnt, key_level, press_p, release_p, and repeat counters SHALL all be 0, asynchronously.
REQ-022 Reset mid-operation SHALL discard partial counts and suppress all pulses; no release_p is generated for keys held at reset.
REQ-023 After rst_n deasserts with a key held high, that key SHALL be debounced from zero and produce press_p per REQ-017.

Configuration
REQ-024 Macro KEY_REPEAT_EN: when defined, each channel SHALL include a repeat counter that clears whenever key_level[i] is 0 or rises.
REQ-025 With KEY_REPEAT_EN, while key_level[i] stays 1, press_p[i] SHALL pulse again after every REPEAT_CYC cycles of hold (first repeat REPEAT_CYC cycles after the initial press pulse), counter restarting after each repeat.
REQ-026 Without KEY_REPEAT_EN, no repeat logic SHALL be synthesized, REPEAT_CYC is ignored, and press_p pulses only on accepted rising transitions.

Verification (N_CH=3, STABLE_CYC=4, REPEAT_CYC=10)
REQ-027 key_in[0] 0->1 held -> key_level[0]=1 and single press_p[0] pulse 6 edges after first sampling edge; release symmetric with release_p[0].
REQ-028 key_in[1] toggles high 3 cycles, low 1, high 3 -> no pulse, key_level[1] stays 0; then held high 4+ cycles -> one press_p[1].
REQ-029 key_in[0] and key_in[2] rise same cycle -> press_p[0] and press_p[2] in the same cycle, channel 1 silent.
REQ-030 Key held, rst_n pulsed low mid-count and again while key_level=1 -> all outputs 0 during reset, no release_p, fresh press_p 6 edges after release of reset.
REQ-031 KEY_REPEAT_EN defined, key_in[0] held 40 cycles -> press_p[0] at initial press, then every 10 cycles (3 repeats), stops on release with one release_p[0]; undefined -> single press_p[0] only.

Source files
------------

// File: rtl/multi_key_debounce_if.sv
// Key bus for multi_key_debounce: raw key levels in, debounced levels and edge pulses out.
interface multi_key_debounce_if #(
  parameter int N_CH = 3
);
  logic [N_CH-1:0] key_in;
  logic [N_CH-1:0] key_level;
  logic [N_CH-1:0] press_p;
  logic [N_CH-1:0] release_p;

  modport master (
    output key_in,
    input  key_level,
    input  press_p,
    input  release_p
  );

  modport slave (
    input  key_in,
    output key_level,
    output press_p,
    output release_p
  );
endinterface

// File: rtl/multi_key_debounce.sv
// Per-channel key debouncer: 2-flop synchronizer, stability counter, registered press/release pulses.
// Define KEY_REPEAT_EN to add per-channel auto-repeat of press_p while a key stays held.
module multi_key_debounce #(
  parameter int N_CH       = 3,
  parameter int CNT_W      = 20,
  parameter int STABLE_CYC = 1000000,
  parameter int REPEAT_CYC = 25000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multi_key_debounce_if.slave  kbus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

`ifdef KEY_REPEAT_EN
  localparam int               REP_W    = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);
`else
  localparam int unused_repeat_cyc = REPEAT_CYC;
`endif

  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_press;
  logic [N_CH-1:0] w_release;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi = gi + 1) begin : g_ch
      logic [1:0]       r_sync;
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;
      logic             r_press;
      logic             r_release;
      logic             w_s;
      logic             w_diff;
      logic             w_accept;
      logic             w_rep_fire;

      assign w_s      = r_sync[1];
      assign w_diff   = w_s ^ r_level;
      // Accept only after STABLE_CYC consecutive differing samples; any match restarts.
      assign w_accept = w_diff && (r_cnt == CNT_LAST);

`ifdef KEY_REPEAT_EN
      logic [REP_W-1:0] r_rep;

      // Suppressed on the falling edge so press and release never coincide.
      assign w_rep_fire = r_level && !w_accept && (r_rep == REP_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rep <= '0;
        end else if (!r_level || w_accept || w_rep_fire) begin
          r_rep <= '0;
        end else begin
          r_rep <= r_rep + 1'b1;
        end
      end
`else
      assign w_rep_fire = 1'b0;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync    <= 2'b00;
          r_cnt     <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_sync <= {r_sync[0], kbus.key_in[gi]};
          if (!w_diff || w_accept) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_accept) begin
            r_level <= w_s;
          end
          r_press   <= (w_accept && w_s) || w_rep_fire;
          r_release <= w_accept && !w_s;
        end
      end

      assign w_level[gi]   = r_level;
      assign w_press[gi]   = r_press;
      assign w_release[gi] = r_release;
    end
  endgenerate

  assign kbus.key_level = w_level;
  assign kbus.press_p   = w_press;
  assign kbus.release_p = w_release;

endmodule

// File: tb/tb_multi_key_debounce.sv
// Scoreboard bench for multi_key_debounce (N_CH=3, STABLE_CYC=4, REPEAT_CYC=10).
module tb_multi_key_debounce;

  localparam int N_CH = 3;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] level;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  ev_t  exp_q[$];

  multi_key_debounce_if #(.N_CH(N_CH)) kbus ();

  multi_key_debounce #(
    .N_CH       (N_CH),
    .CNT_W      (20),
    .STABLE_CYC (4),
    .REPEAT_CYC (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kbus  (kbus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.level = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   int'(kbus.key_level), 0);
    chk({tag, "_press"},   int'(kbus.press_p),   0);
    chk({tag, "_release"}, int'(kbus.release_p), 0);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missed_pulse_cycle", cyc, e.cyc);
    end
    if (kbus.press_p != 3'b000 || kbus.release_p != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", int'({kbus.press_p, kbus.release_p}), 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle",   cyc, e.cyc);
        chk("pulse_press",   int'(kbus.press_p),   int'(e.press));
        chk("pulse_release", int'(kbus.release_p), int'(e.rel));
        chk("pulse_level",   int'(kbus.key_level), int'(e.level));
        $display("[TB] cycle %0d press=%b release=%b level=%b", cyc, kbus.press_p, kbus.release_p, kbus.key_level);
      end
    end
  end

  initial begin
    kbus.key_in = 3'b000;
    wait_n(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    wait_n(3);

    // Single press and release on channel 0.
    kbus.key_in = 3'b001;
    push(cyc + 6, 3'b001, 3'b000, 3'b001);
    wait_n(8);
    chk("ch0_level_high", int'(kbus.key_level), 1);
    kbus.key_in = 3'b000;
    push(cyc + 6, 3'b000, 3'b001, 3'b000);
    wait_n(8);
    chk("ch0_level_low", int'(kbus.key_level), 0);

    // Channel 1 glitches shorter than the stability window.
    for (int k = 0; k < 2; k++) begin
      kbus.key_in = 3'b010;
      wait_n(3);
      kbus.key_in = 3'b000;
      wait_n(1);
    end
    wait_n(4);
    chk("ch1_glitch_level", int'(kbus.key_level), 0);
    kbus.key_in = 3'b010;
    push(cyc + 6, 3'b010, 3'b000, 3'b010);
    wait_n(8);
    chk("ch1_level_high", int'(kbus.key_level), 2);
    kbus.key_in = 3'b000;
    push(cyc + 6, 3'b000, 3'b010, 3'b000);
    wait_n(8);

    // Channels 0 and 2 together.
    kbus.key_in = 3'b101;
    push(cyc + 6, 3'b101, 3'b000, 3'b101);
    wait_n(8);
    chk("ch02_level", int'(kbus.key_level), 5);
    kbus.key_in = 3'b000;
    push(cyc + 6, 3'b000, 3'b101, 3'b000);
    wait_n(8);

    // Reset mid-count, then again while the level is high.
    kbus.key_in = 3'b001;
    wait_n(3);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_midcount");
    wait_n(2);
    chk_all_zero("rst_hold");
    rst_n = 1'b1;
    push(cyc + 6, 3'b001, 3'b000, 3'b001);
    wait_n(8);
    chk("rst_level_high", int'(kbus.key_level), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_while_high");
    wait_n(2);
    rst_n = 1'b1;
    push(cyc + 6, 3'b001, 3'b000, 3'b001);
    wait_n(8);
    kbus.key_in = 3'b000;
    push(cyc + 6, 3'b000, 3'b001, 3'b000);
    wait_n(10);

    // Long hold on channel 0: auto-repeat when enabled.
    kbus.key_in = 3'b001;
    push(cyc + 6, 3'b001, 3'b000, 3'b001);
`ifdef KEY_REPEAT_EN
    push(cyc + 16, 3'b001, 3'b000, 3'b001);
    push(cyc + 26, 3'b001, 3'b000, 3'b001);
    push(cyc + 36, 3'b001, 3'b000, 3'b001);
`endif
    wait_n(40);
    kbus.key_in = 3'b000;
    push(cyc + 6, 3'b000, 3'b001, 3'b000);
    wait_n(12);
    chk("final_level", int'(kbus.key_level), 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
